data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the core's load/store port. It accepts word-aligned read and write requests from the memory execute unit, applies per-byte write enables, and returns read data with a configurable number of wait states. Optionally, it flags out-of-range accesses. It sits outside the core, at the far end of the data-memory interface that the core's LB/LH/LW/SB/SH/SW path drives.

## Interface
- `MEM_BYTES`, default 65536: storage size in bytes; power of two, ≥ 4.
- `WAIT_STATES`, default 0: extra cycles between accept and response; range 0–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  request valid.
- `ready_o`  out  1  block can accept a request this cycle.
- `we_i`  in  4  byte write enables; lane n covers `wdata_i[8n+7:8n]`. All zero means a read.
- `addr_i`  in  32  byte address; bits [1:0] are ignored.
- `wdata_i`  in  32  write data, already lane-aligned by the core.
- `rvalid_o`  out  1  response valid, one-cycle pulse.
- `rdata_o`  out  32  read word; 0 for writes and errors.
- `err_o`  out  1  response is an error; qualified by `rvalid_o`.

## Operation
- A request is accepted when `req_i` and `ready_o` are both high in the same cycle. `addr_i`, `we_i` and `wdata_i` are captured on that edge.
- Word index is `addr_i[log2(MEM_BYTES)-1:2]`.
- The FSM has three states: IDLE, WAIT and RESP.
  - IDLE: `ready_o`=1. On accept, go to RESP if `WAIT_STATES`=0; otherwise go to WAIT and load the counter with `WAIT_STATES`-1.
  - WAIT: `ready_o`=0. The counter decrements each cycle. At counter = 0, go to RESP.
  - RESP: `rvalid_o`=1 and `ready_o`=1. An accept in this cycle follows the same rules as in IDLE. With no accept, go to IDLE.
- The memory access happens on the edge that enters RESP:
  - For a write, only enabled lanes are updated.
  - For a read, the whole word is registered into `rdata_o`.
- Accesses complete in acceptance order. A read that follows a write to the same word returns the written data.
- Mixed `we_i` patterns, for example 4'b0110, are legal and written as given. The responder does no sign extension; that is the core's job.
- `reset` mid-operation forces IDLE and cancels the pending request: no response is produced and no write is committed. Storage contents are not cleared by reset.

## Timing
- Reset values: `ready_o`=1, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, counter = 0.
- Requests are ignored while `reset` is high.
- Latency from the accept edge to `rvalid_o` high is 1 + `WAIT_STATES` cycles.
- Throughput:
  - `WAIT_STATES`=0: one request per cycle, back-to-back with no bubbles.
  - Otherwise: one request per 1 + `WAIT_STATES` cycles.
- `rdata_o` and `err_o` hold their values only while `rvalid_o` is high. In all other cycles they are 0.

## Configuration
- Macro: `DATA_MEM_BOUNDS_CHECK_EN`.
- Defined:
  - An address ≥ `MEM_BYTES` returns `err_o`=1 and `rdata_o`=0, and the write is suppressed.
  - Error latency is identical to normal access latency.
- Undefined:
  - Upper address bits are discarded, so accesses alias modulo `MEM_BYTES`.
  - `err_o` is tied to 0.

## Structure
- Shared package holds:
  - the FSM state typedef (`MEM_IDLE`, `MEM_WAIT`, `MEM_RESP`);
  - the default memory-size constant, used as the default for `MEM_BYTES`.
- Sub-module `byte_lane_ram`: four 8-bit-wide synchronous RAM lanes with per-lane write enable and one registered read port. The top level keeps the FSM, counter, bounds check and output gating.

## Test plan
- Byte-lane write: write 0xDEADBEEF to 0x100 with `we`=1111, then write 0x0000AB00 to 0x100 with `we`=0010, then read 0x100 → `rdata_o`=0xDEADABEF and `err_o`=0.
- Latency and ready gating: `WAIT_STATES`=3 and a read accepted at cycle t → `rvalid_o` high only at t+4; `ready_o`=0 during cycles t+1 to t+3.
- Back-to-back ordering: `WAIT_STATES`=0, `req_i` held high for write 0x11223344 to 0x8, then read 0x8, then read 0xC → three consecutive `rvalid_o` pulses. The second returns 0x11223344; the third returns the prior contents of 0xC.
- Bounds check, macro defined: write to 0x10000 with `MEM_BYTES`=65536 → `err_o`=1 and `rdata_o`=0; a following read of 0x0 is unchanged.
- Bounds check, macro undefined: the same write aliases to 0x0, and a read of 0x0 returns the written word.
- Reset mid-WAIT: `WAIT_STATES`=2, write 0xCAFEF00D to 0x40, assert `reset` one cycle after accept → no `rvalid_o` pulse, and a later read of 0x40 returns the old value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: FSM state type and default storage size shared by data_mem_responder and its RAM.
package data_mem_responder_pkg;

    localparam int DEFAULT_MEM_BYTES = 65536;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } mem_state_e;

endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// byte_lane_ram: four 8-bit synchronous RAM lanes with per-lane write enable and one registered read port.
module byte_lane_ram
    import data_mem_responder_pkg::*;
#(
    parameter int WORDS = DEFAULT_MEM_BYTES / 4,
    parameter int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_q;
        // The read register only loads on reads, so a write never disturbs it.
        always_ff @(posedge clk) begin
            if (en && we[g]) mem[idx] <= wdata[8*g +: 8];
            if (en && we == 4'b0000) rd_q <= mem[idx];
        end
        assign rdata[8*g +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store memory responder with byte enables and WAIT_STATES wait cycles.
// Define DATA_MEM_BOUNDS_CHECK_EN to flag addresses >= MEM_BYTES as errors instead of aliasing them.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_BYTES   = DEFAULT_MEM_BYTES,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    output logic        ready_o,
    input  logic [3:0]  we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         AW        = $clog2(MEM_BYTES);
    localparam int         WORDS     = MEM_BYTES / 4;
    localparam int         IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    mem_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    we_q, we_d;
    logic          rd_q, rd_d;
    logic          err_q, err_d;
    logic          accept, acc_en, acc_oob;
    logic [31:0]   acc_addr, acc_wdata, ram_rdata;
    logic [3:0]    acc_we;
    logic [IW-1:0] acc_idx;

    assign ready_o  = (state_q != MEM_WAIT);
    assign rvalid_o = (state_q == MEM_RESP);
    assign rdata_o  = (rvalid_o && rd_q) ? ram_rdata : 32'd0;
    assign err_o    = rvalid_o && err_q;

    assign accept = req_i && ready_o && !reset;

    // The access happens on the edge entering RESP: straight from the port with no wait
    // states, otherwise from the captured request once the counter has run out.
    assign acc_en    = NO_WAIT ? accept : (state_q == MEM_WAIT && cnt_q == 4'd0);
    assign acc_addr  = NO_WAIT ? addr_i : addr_q;
    assign acc_we    = NO_WAIT ? we_i : we_q;
    assign acc_wdata = NO_WAIT ? wdata_i : wdata_q;
    assign acc_idx   = IW'((acc_addr >> 2) & 32'(WORDS - 1));

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    assign acc_oob = ((acc_addr >> AW) != 32'd0);
`else
    assign acc_oob = 1'b0;
`endif

    always_comb begin
        state_d = accept ? (NO_WAIT ? MEM_RESP : MEM_WAIT)
                : (state_q == MEM_WAIT) ? ((cnt_q == 4'd0) ? MEM_RESP : MEM_WAIT)
                : MEM_IDLE;
        cnt_d   = (accept && !NO_WAIT) ? WAIT_LOAD
                : (state_q == MEM_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1
                : cnt_q;
        addr_d  = accept ? addr_i : addr_q;
        we_d    = accept ? we_i : we_q;
        wdata_d = accept ? wdata_i : wdata_q;
        rd_d    = acc_en ? (acc_we == 4'b0000 && !acc_oob) : rd_q;
        err_d   = acc_en ? acc_oob : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 4'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    byte_lane_ram #(
        .WORDS (WORDS),
        .IW    (IW)
    ) u_ram (
        .clk   (clk),
        .en    (acc_en),
        .we    (acc_oob ? 4'b0000 : acc_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench driving three responders (0, 3 and 2 wait states).
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req   [3];
    logic [3:0]  we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        rv    [3];
    logic        err   [3];

    exp_t        q0[$], q1[$], q2[$];
    logic [31:0] mdl [int];
    int          nchk = 0;
    int          nerr = 0;
    int          n;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
    endfunction

    task automatic push(input int s, input exp_t e);
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int s, output exp_t e);
        case (s)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    function automatic int key(input int s, input logic [31:0] a);
        return s * 65536 + int'((a >> 2) & 32'h3FFF);
    endfunction

    function automatic logic oob(input logic [31:0] a);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        return a >= 32'h10000;
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic mon(input int s);
        exp_t e;
        if (rv[s]) begin
            if (qsize(s) == 0) check($sformatf("unexpected_rvalid%0d", s), 32'd1, 32'd0);
            else begin
                pop(s, e);
                check($sformatf("rdata%0d", s), rdata[s], e.d);
                check($sformatf("err%0d", s), 32'(err[s]), 32'(e.e));
            end
        end else begin
            check($sformatf("idle_rdata%0d", s), rdata[s], 32'd0);
            check($sformatf("idle_err%0d", s), 32'(err[s]), 32'd0);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .MEM_BYTES   (65536),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_i    (req[g]),
            .ready_o  (rdy[g]),
            .we_i     (we[g]),
            .addr_i   (addr[g]),
            .wdata_i  (wdata[g]),
            .rvalid_o (rv[g]),
            .rdata_o  (rdata[g]),
            .err_o    (err[g])
        );
        always @(negedge clk) mon(g);
    end

    // Drives one request from a negedge, waits for ready, records the expected response
    // from the bench model and returns at the negedge after the accept edge.
    task automatic send(input int s, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input bit expect_rsp, output int waited);
        exp_t        e;
        int          k;
        logic [31:0] m;
        waited   = 0;
        req[s]   = 1'b1;
        we[s]    = w;
        addr[s]  = a;
        wdata[s] = d;
        while (!rdy[s] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check($sformatf("ready_timeout%0d", s), 32'(waited), 32'd0);
        k   = key(s, a);
        m   = mdl.exists(k) ? mdl[k] : 32'd0;
        e.e = oob(a);
        e.d = (!e.e && w == 4'b0000) ? m : 32'd0;
        if (expect_rsp) begin
            if (!e.e && w != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (w[i]) m[8*i +: 8] = d[8*i +: 8];
                mdl[k] = m;
            end
            push(s, e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int s);
        req[s] = 1'b0;
        we[s]  = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            req[s] = 1'b0; we[s] = 4'b0; addr[s] = 32'd0; wdata[s] = 32'd0;
        end
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_ready%0d", s), 32'(rdy[s]), 32'd1);
            check($sformatf("rst_rvalid%0d", s), 32'(rv[s]), 32'd0);
            check($sformatf("rst_rdata%0d", s), rdata[s], 32'd0);
            check($sformatf("rst_err%0d", s), 32'(err[s]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            send(s, 4'b1111, 32'h100, 32'hDEADBEEF, 1, n);
            send(s, 4'b0010, 32'h100, 32'h0000AB00, 1, n);
            send(s, 4'b0000, 32'h100, 32'h0, 1, n);
            send(s, 4'b1111, 32'h104, 32'h01020304, 1, n);
            send(s, 4'b0110, 32'h106, 32'hAABBCCDD, 1, n);
            send(s, 4'b0000, 32'h104, 32'h0, 1, n);
            idle(s);
            repeat (6) @(negedge clk);
        end

        send(1, 4'b1111, 32'h200, 32'h0BADCAFE, 1, n);
        idle(1);
        repeat (6) @(negedge clk);
        check("lat_ready_t", 32'(rdy[1]), 32'd1);
        send(1, 4'b0000, 32'h200, 32'h0, 1, n);
        idle(1);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("lat_rvalid_t%0d", k), 32'(rv[1]), 32'd0);
            check($sformatf("lat_ready_t%0d", k), 32'(rdy[1]), 32'd0);
            @(negedge clk);
        end
        check("lat_rvalid_t4", 32'(rv[1]), 32'd1);
        check("lat_ready_t4", 32'(rdy[1]), 32'd1);
        repeat (3) @(negedge clk);

        send(0, 4'b1111, 32'hC, 32'h55667788, 1, n);
        idle(0);
        repeat (3) @(negedge clk);
        send(0, 4'b1111, 32'h8, 32'h11223344, 1, n);
        check("b2b_wait1", 32'(n), 32'd0);
        check("b2b_rvalid1", 32'(rv[0]), 32'd1);
        send(0, 4'b0000, 32'h8, 32'h0, 1, n);
        check("b2b_wait2", 32'(n), 32'd0);
        check("b2b_rvalid2", 32'(rv[0]), 32'd1);
        send(0, 4'b0000, 32'hC, 32'h0, 1, n);
        check("b2b_wait3", 32'(n), 32'd0);
        check("b2b_rvalid3", 32'(rv[0]), 32'd1);
        idle(0);
        @(negedge clk);
        check("b2b_rvalid_end", 32'(rv[0]), 32'd0);
        repeat (2) @(negedge clk);

        send(0, 4'b1111, 32'h0, 32'hA5A5A5A5, 1, n);
        send(0, 4'b1111, 32'h10000, 32'h99887766, 1, n);
        send(0, 4'b0000, 32'h0, 32'h0, 1, n);
        send(0, 4'b0000, 32'h10000, 32'h0, 1, n);
        idle(0);
        repeat (4) @(negedge clk);

        send(2, 4'b1111, 32'h40, 32'h12345678, 1, n);
        idle(2);
        repeat (5) @(negedge clk);
        send(2, 4'b1111, 32'h40, 32'hCAFEF00D, 0, n);
        idle(2);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_ready", 32'(rdy[2]), 32'd1);
        check("rst_mid_rvalid", 32'(rv[2]), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send(2, 4'b0000, 32'h40, 32'h0, 1, n);
        idle(2);

        repeat (8) @(negedge clk);
        for (int s = 0; s < 3; s++) check($sformatf("pending%0d", s), 32'(qsize(s)), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
